// File: rtl/ofm_drain.sv
// ofm_drain: readback engine for the output feature-map buffer.
// Reads num_words packed words starting at base_addr, splits each word into
// LANES lanes (most-significant lane first) and streams them over valid/ready.
// Configuration macro: OFM_DRAIN_RELU_EN -- when defined, negative lanes are
// clamped to zero on the way out (combinational, no added latency).
module ofm_drain #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int LANE_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [ADDR_W:0]              num_words,
  output logic                         mem_ena,
  output logic [(DATA_W/LANE_W)*2-1:0] mem_wea,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_dout,
  output logic [LANE_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int LANES  = DATA_W / LANE_W;
  localparam int LSEL_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WAIT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [LSEL_W-1:0]   lane_q, lane_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [LANE_W-1:0]   lane_raw;
  logic [LANE_W-1:0]   lane_out;
  logic                xfer;

  // Output decode: everything is a function of registered state only.
  assign out_valid = (state_q == S_EMIT);
  assign mem_ena   = (state_q == S_FETCH);
  assign mem_addr  = addr_q;
  assign mem_wea   = '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign xfer      = out_valid & out_ready;
  // Outside EMIT the lane bus is parked at zero so stale words never leak out.
  assign out_data  = out_valid ? lane_out : {LANE_W{1'b0}};

  // Lane select (lane 0 is the top slice of the word) plus optional clamp.
  always_comb begin
    lane_raw = word_q[(DATA_W-1) - (int'(lane_q) * LANE_W) -: LANE_W];
`ifdef OFM_DRAIN_RELU_EN
    if (lane_raw[LANE_W-1]) begin
      lane_out = {LANE_W{1'b0}};
    end else begin
      lane_out = lane_raw;
    end
`else
    lane_out = lane_raw;
`endif
  end

  // Next-state and datapath update for the drain FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    word_d   = word_q;
    lane_d   = lane_q;
    wait_d   = wait_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words == {(ADDR_W+1){1'b0}}) begin
            state_d = S_FIN;
          end else begin
            addr_d   = base_addr;
            remain_d = num_words;
            lane_d   = {LSEL_W{1'b0}};
            state_d  = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        wait_d  = {WAIT_W{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Read data is valid on the final wait cycle; capture it then.
        if (wait_q == WAIT_W'(RD_LAT - 1)) begin
          word_d  = mem_dout;
          lane_d  = {LSEL_W{1'b0}};
          state_d = S_EMIT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (xfer) begin
          if (lane_q == LSEL_W'(LANES - 1)) begin
            lane_d   = {LSEL_W{1'b0}};
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            if (remain_q == (ADDR_W+1)'(1)) begin
              state_d = S_FIN;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partially drained word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= {ADDR_W{1'b0}};
      remain_q <= {(ADDR_W+1){1'b0}};
      word_q   <= {DATA_W{1'b0}};
      lane_q   <= {LSEL_W{1'b0}};
      wait_q   <= {WAIT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      word_q   <= word_d;
      lane_q   <= lane_d;
      wait_q   <= wait_d;
    end
  end

endmodule
